// File: rtl/v_line_in.sv
// Input-side router for one vertical line: synchronizes the pad buses and steers them
// to the macro slot picked by the active configuration, with a quiesced config switch.
module v_line_in #(
  parameter int POSITION       = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int QUIESCE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [3:0]  config_i,
  input  logic        config_valid_i,
  output logic        config_ready_o,
  output logic [3:0]  active_config_o,
  output logic        busy_o,
  input  logic [9:0]  north_pad_i,
  input  logic [13:0] west_pad_i,
  input  logic [13:0] east_pad_i,
  output logic [9:0]  north_i_0,
  output logic [9:0]  north_i_1,
  output logic [13:0] west_i_0,
  output logic [13:0] west_i_1,
  output logic [13:0] west_i_2,
  output logic [13:0] east_i_0,
  output logic [13:0] east_i_1,
  output logic [13:0] east_i_2
);

  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  pending_q;
  logic [3:0]  active_q;
  logic        ready_q;
  logic        busy_q;

  logic [9:0]  north_sync_q [SYNC_STAGES];
  logic [13:0] west_sync_q  [SYNC_STAGES];
  logic [13:0] east_sync_q  [SYNC_STAGES];

  logic [9:0]  north_d [2];
  logic [9:0]  north_q [2];
  logic [13:0] west_d  [3];
  logic [13:0] west_q  [3];
  logic [13:0] east_d  [3];
  logic [13:0] east_q  [3];

  logic [1:0]  sel;

  // Routing table for this line; unlisted configs and positions fall back to slot 0.
  always_comb begin
    sel = 2'd0;
    if (POSITION == 0) begin
      case (active_q)
        4'd1:    sel = 2'd2;
        4'd2:    sel = 2'd1;
        4'd3:    sel = 2'd2;
        default: sel = 2'd0;
      endcase
    end else if (POSITION == 1) begin
      case (active_q)
        4'd2, 4'd3: sel = 2'd1;
        default:    sel = 2'd0;
      endcase
    end else if (POSITION == 2) begin
      case (active_q)
        4'd0, 4'd2: sel = 2'd2;
        4'd3:       sel = 2'd1;
        default:    sel = 2'd0;
      endcase
    end
  end

  // NOTE: the synchronizer arrays are small flop banks, not RAM, so they are reset
  // explicitly; this keeps stale pad data out of the output stage after reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        north_sync_q[i] <= '0;
        west_sync_q[i]  <= '0;
        east_sync_q[i]  <= '0;
      end
    end else begin
      north_sync_q[0] <= north_pad_i;
      west_sync_q[0]  <= west_pad_i;
      east_sync_q[0]  <= east_pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        north_sync_q[i] <= north_sync_q[i-1];
        west_sync_q[i]  <= west_sync_q[i-1];
        east_sync_q[i]  <= east_sync_q[i-1];
      end
    end
  end

  // NOTE: every _d gets a zero default before the steering case, so no latch is
  // inferred and unselected slots never hold stale data.
  always_comb begin
    for (int i = 0; i < 2; i++) north_d[i] = '0;
    for (int i = 0; i < 3; i++) begin
      west_d[i] = '0;
      east_d[i] = '0;
    end
    if (state_q == IDLE) begin
      if (sel[0]) north_d[1] = north_sync_q[SYNC_STAGES-1];
      else        north_d[0] = north_sync_q[SYNC_STAGES-1];
      case (sel)
        2'd0: begin
          west_d[0] = west_sync_q[SYNC_STAGES-1];
          east_d[0] = east_sync_q[SYNC_STAGES-1];
        end
        2'd1: begin
          west_d[1] = west_sync_q[SYNC_STAGES-1];
          east_d[1] = east_sync_q[SYNC_STAGES-1];
        end
        2'd2: begin
          west_d[2] = west_sync_q[SYNC_STAGES-1];
          east_d[2] = east_sync_q[SYNC_STAGES-1];
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < 2; i++) north_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        west_q[i] <= '0;
        east_q[i] <= '0;
      end
    end else begin
      north_q <= north_d;
      west_q  <= west_d;
      east_q  <= east_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (config_valid_i && ready_q) begin
            pending_q <= config_i;
            // A request for the already-active config is accepted without a drain.
            if (config_i != active_q) begin
              cnt_q   <= 4'(QUIESCE_CYCLES - 1);
              state_q <= DRAIN;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == 4'd0) state_q <= SWITCH;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        SWITCH: begin
          active_q <= pending_q;
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign config_ready_o  = ready_q;
  assign busy_o          = busy_q;
  assign active_config_o = active_q;

  assign north_i_0 = north_q[0];
  assign north_i_1 = north_q[1];
  assign west_i_0  = west_q[0];
  assign west_i_1  = west_q[1];
  assign west_i_2  = west_q[2];
  assign east_i_0  = east_q[0];
  assign east_i_1  = east_q[1];
  assign east_i_2  = east_q[2];

endmodule

// File: tb/tb_v_line_in.sv
// Directed bench for v_line_in: one instance per line position, shared stimulus,
// expected routing computed from the slot-select table.
module tb_v_line_in;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cfg;
  logic        cfg_valid;
  logic [9:0]  north;
  logic [13:0] west;
  logic [13:0] east;

  logic        ready_o  [3];
  logic [3:0]  active_o [3];
  logic        busy_o   [3];
  logic [9:0]  n0 [3];
  logic [9:0]  n1 [3];
  logic [13:0] w0 [3];
  logic [13:0] w1 [3];
  logic [13:0] w2 [3];
  logic [13:0] e0 [3];
  logic [13:0] e1 [3];
  logic [13:0] e2 [3];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    v_line_in #(.POSITION(g), .SYNC_STAGES(2), .QUIESCE_CYCLES(4)) dut (
      .wb_clk_i        (clk),
      .wb_rst_n        (rst_n),
      .config_i        (cfg),
      .config_valid_i  (cfg_valid),
      .config_ready_o  (ready_o[g]),
      .active_config_o (active_o[g]),
      .busy_o          (busy_o[g]),
      .north_pad_i     (north),
      .west_pad_i      (west),
      .east_pad_i      (east),
      .north_i_0       (n0[g]),
      .north_i_1       (n1[g]),
      .west_i_0        (w0[g]),
      .west_i_1        (w1[g]),
      .west_i_2        (w2[g]),
      .east_i_0        (e0[g]),
      .east_i_1        (e1[g]),
      .east_i_2        (e2[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_sel(input int p, input logic [3:0] c);
    logic [1:0] s;
    s = 2'd0;
    if (c <= 4'd3) begin
      case (p)
        0: case (c) 4'd0: s = 2'd0; 4'd1: s = 2'd2; 4'd2: s = 2'd1; default: s = 2'd2; endcase
        1: case (c) 4'd0: s = 2'd0; 4'd1: s = 2'd0; 4'd2: s = 2'd1; default: s = 2'd1; endcase
        2: case (c) 4'd0: s = 2'd2; 4'd1: s = 2'd0; 4'd2: s = 2'd2; default: s = 2'd1; endcase
        default: s = 2'd0;
      endcase
    end
    return s;
  endfunction

  // Packed view {n0,n1,w0,w1,w2,e0,e1,e2} of one instance.
  function automatic logic [127:0] act_pack(input int p);
    return {24'd0, n0[p], n1[p], w0[p], w1[p], w2[p], e0[p], e1[p], e2[p]};
  endfunction

  function automatic logic [127:0] exp_pack(input logic [1:0] s, input logic [9:0] n,
                                            input logic [13:0] w, input logic [13:0] e);
    logic [9:0]  en0, en1;
    logic [13:0] ew0, ew1, ew2, ee0, ee1, ee2;
    en0 = s[0] ? 10'd0 : n;
    en1 = s[0] ? n : 10'd0;
    ew0 = (s == 2'd0) ? w : 14'd0;
    ew1 = (s == 2'd1) ? w : 14'd0;
    ew2 = (s == 2'd2) ? w : 14'd0;
    ee0 = (s == 2'd0) ? e : 14'd0;
    ee1 = (s == 2'd1) ? e : 14'd0;
    ee2 = (s == 2'd2) ? e : 14'd0;
    return {24'd0, en0, en1, ew0, ew1, ew2, ee0, ee1, ee2};
  endfunction

  task automatic check_routes(input string tag, input logic [3:0] c);
    for (int p = 0; p < 3; p++)
      check($sformatf("%s_routes_p%0d", tag, p), act_pack(p), exp_pack(exp_sel(p, c), north, west, east));
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < 3; p++)
      check($sformatf("%s_zero_p%0d", tag, p), act_pack(p), 128'd0);
  endtask

  task automatic check_ctrl(input string tag, input logic rdy, input logic bsy, input logic [3:0] act);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("%s_ready_p%0d", tag, p), 128'(ready_o[p]), 128'(rdy));
      check($sformatf("%s_busy_p%0d", tag, p), 128'(busy_o[p]), 128'(bsy));
      check($sformatf("%s_active_p%0d", tag, p), 128'(active_o[p]), 128'(act));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg       = 4'd0;
    cfg_valid = 1'b0;
    north     = 10'($urandom);
    west      = 14'($urandom);
    east      = 14'($urandom);

    // Reset with random pads
    repeat (3) tick();
    check_zero("reset");
    check_ctrl("reset", 1'b1, 1'b0, 4'd0);

    // Latency: pads set right after an edge appear after three edges
    north = 10'h155;
    west  = 14'h02A5;
    east  = 14'h1C3;
    rst_n = 1'b1;
    tick();
    tick();
    check_zero("lat2");
    tick();
    check_routes("lat3", 4'd0);

    // Same-config request: no drain, no gap
    cfg = 4'd0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_ctrl($sformatf("same%0d", k), 1'b1, 1'b0, 4'd0);
      check_routes($sformatf("same%0d", k), 4'd0);
      tick();
    end

    // Switch to cfg 1 with drain; pads change mid-drain
    cfg = 4'd1;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_ctrl("hs", 1'b0, 1'b1, 4'd0);
    check_routes("hs", 4'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_zero($sformatf("drain%0d", k));
      check_ctrl($sformatf("drain%0d", k), 1'b0, 1'b1, 4'd0);
      if (k == 2) begin
        north = 10'h2CA;
        west  = 14'h3A5C;
        east  = 14'h0F0F;
      end
    end
    tick();
    check_ctrl("switch", 1'b1, 1'b0, 4'd1);
    check_zero("switch");
    tick();
    check_routes("cfg1", 4'd1);

    // Out-of-range config: every line falls back to slot 0
    cfg = 4'd9;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (5) tick();
    check_ctrl("cfg9", 1'b1, 1'b0, 4'd9);
    tick();
    check_routes("cfg9", 4'd9);

    // Reset in the middle of a drain
    cfg = 4'd2;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    check_ctrl("mid_drain", 1'b0, 1'b1, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_drain");
    check_ctrl("rst_drain", 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check_zero("refill");
    tick();
    check_routes("refilled", 4'd0);
    check_ctrl("refilled", 1'b1, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v_line_in.md
Name: v_line_in

Overview:
- Input-direction companion of the vertical-line output mux: distributes pad inputs (north, west, east) from one vertical line to the macro slot chosen by the array configuration.
- Synchronizes pad inputs and registers the routed values.
- Applies a new configuration through a ready/valid handshake with a quiesce window, so no macro sees glitched or misrouted inputs during a switch.
- Sits between the pad ring and the macro array; one instance per vertical line.

Parameters:
- POSITION, 0, index of the vertical line (0..2); selects the routing table.
- SYNC_STAGES, 2, number of synchronizer flops on each pad input (legal 1..3).
- QUIESCE_CYCLES, 4, cycles all macro inputs are held at 0 before a configuration switch (legal 1..15).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- config_i  in  4  requested configuration
- config_valid_i  in  1  config_i is valid
- config_ready_o  out  1  block can accept a configuration
- active_config_o  out  4  configuration currently applied
- busy_o  out  1  drain or switch in progress
- north_pad_i  in  10  north pad inputs
- west_pad_i  in  14  west pad inputs
- east_pad_i  in  14  east pad inputs
- north_i_0, north_i_1  out  10 each  north inputs to macro slots 0/1
- west_i_0, west_i_1, west_i_2  out  14 each  west inputs to macro slots 0..2
- east_i_0, east_i_1, east_i_2  out  14 each  east inputs to macro slots 0..2

Behaviour:
- Slot select sel[1:0] is a function of active_config and POSITION:
  - POSITION 0: cfg 0→0, 1→2, 2→1, 3→2.
  - POSITION 1: cfg 0→0, 1→0, 2→1, 3→1.
  - POSITION 2: cfg 0→2, 1→0, 2→2, 3→1.
  - Any cfg >3, or any other POSITION: sel = 0.
- North slot = sel[0]. West and east slot = sel.
- Each pad bus passes through SYNC_STAGES flops, then one output register.
- Pad-to-macro latency is SYNC_STAGES+1 cycles; 3 cycles at default.
- Selected slot's outputs carry the synchronized pad value. All unselected slots' outputs are 0 (never stale data).
- Reset (async assert, deassert sampled on the clock):
  - All sync flops, all macro outputs, and active_config_o = 0.
  - State IDLE, config_ready_o = 1, busy_o = 0.
- FSM states: IDLE, DRAIN, SWITCH.
- IDLE:
  - Normal routing; config_ready_o = 1.
  - Handshake occurs when config_valid_i && config_ready_o at a clock edge; config_i is captured into a pending register.
  - If the captured value equals active_config: stay IDLE, no drain, no output disturbance.
  - Otherwise: go to DRAIN and load the counter with QUIESCE_CYCLES−1.
- DRAIN:
  - All macro outputs forced to 0 from the next edge onward.
  - config_ready_o = 0, busy_o = 1.
  - Counter decrements each cycle; on reaching 0, go to SWITCH.
  - Outputs are zero for exactly QUIESCE_CYCLES cycles.
- SWITCH (one cycle):
  - active_config_o ← pending; outputs still 0; busy_o = 1; then go to IDLE.
  - Routing with the new select resumes on the first IDLE cycle; the synchronizer keeps running throughout, so data is current immediately.
- config_valid_i while not ready: ignored; the requester must hold it until ready.
- Back-to-back requests: a new handshake is possible on the first IDLE cycle after SWITCH.
- Reset asserted mid-DRAIN or mid-SWITCH: pending request discarded; active_config returns to 0.
- Pad toggles during DRAIN/SWITCH are not forwarded. After return to IDLE, the first routed value is the synchronized pad value of that cycle.

Test Plan:
- Reset check: wb_rst_n low with random pads → all macro outputs 0, active_config_o = 0, config_ready_o = 1, busy_o = 0.
- Latency and routing: POSITION=0, cfg 0, west_pad_i = 14'h2A5 set at cycle t → west_i_0 = 14'h2A5 at t+3; west_i_1 = west_i_2 = 0.
- Switch with drain: POSITION=0, request cfg 1 at cycle t →
  - config_ready_o = 0 and outputs 0 during t+1..t+4;
  - SWITCH at t+5, active_config_o = 1 after the t+5 edge;
  - east_i_2 carries east_pad_i from t+6; north_i_0 is active (sel = 2, sel[0] = 0).
- Same-config request: cfg 0 requested while active is 0 → busy_o stays 0, no zero gap on outputs.
- Out-of-range configuration: POSITION=2, cfg 9 → sel 0; north_i_0, west_i_0, east_i_0 active.
- Reset during DRAIN: request cfg 2, assert wb_rst_n at DRAIN cycle 2 → state IDLE, active_config_o = 0, outputs 0 until the synchronizer refills.
